// File: rtl/fetch_queue_if.sv
// Fetch queue handshake bundle: instruction memory port and decode port.
// master is the fetch unit side, slave is the memory/decode side.
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic [CNT_W-1:0]  occupancy;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc, occupancy,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc, occupancy,
    output inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding imem request feeding a
// small instruction queue, with redirect flush and response drop.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    WAIT_DROP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;

  logic req;
  logic acc;
  logic push;
  logic pop;

  // Only IDLE can request, so a free slot here is the reservation.
  assign req  = (state == IDLE) && !rst
              && (count < CNT_W'(DEPTH))
              && !bus.redirect_valid;
  assign acc  = req && bus.imem_req_ready;
  assign push = (state == WAIT_RSP) && bus.imem_rsp_valid
              && !bus.redirect_valid;
  assign pop  = (count != '0) && bus.inst_ready;

  assign bus.imem_req_valid = req;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (count != '0);
  assign bus.inst_data      = data_q[rptr];
  assign bus.inst_pc        = pc_q[rptr];
  assign bus.occupancy      = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      if (bus.redirect_valid)
        pc <= bus.redirect_pc & ~ADDR_W'(3);
      else if (acc)
        pc <= pc + ADDR_W'(4);

      if (acc)
        pend_pc <= pc;

      unique case (state)
        IDLE: begin
          if (acc)
            state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (bus.imem_rsp_valid)
            state <= IDLE;
          else if (bus.redirect_valid)
            state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (bus.imem_rsp_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (bus.redirect_valid) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push)
          wptr <= wptr + PTR_W'(1);
        if (pop)
          rptr <= rptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr] <= bus.imem_rsp_data;
      pc_q[wptr]   <= pend_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, queue full,
// redirect drop paths, PC wrap and reset mid-request.
module tb_fetch_queue;
  logic clk;
  logic rst;

  fetch_queue_if #(.ADDR_W(32), .DEPTH(4)) bus ();

  fetch_queue #(
    .ADDR_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nreq   = 0;
  bit auto_rsp = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; memory is always ready and answers one cycle later.
  task automatic tick();
    logic        a;
    logic [31:0] aa;
    @(posedge clk);
    a  = bus.imem_req_valid && bus.imem_req_ready;
    aa = bus.imem_req_addr;
    #1;
    if (a) nreq++;
    if (auto_rsp) begin
      bus.imem_rsp_valid = a;
      bus.imem_rsp_data  = {16'hC0DE, aa[15:0]};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    nreq = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b1;

    // Sequential fetch with decode always ready
    do_reset();
    chk("rst_occ", 64'(bus.occupancy), 0);
    chk("rst_ival", 64'(bus.inst_valid), 0);
    chk("rst_req", 64'(bus.imem_req_valid), 0);
    rst = 1'b0;
    #1;
    chk("seq_req0_v", 64'(bus.imem_req_valid), 1);
    chk("seq_req0_a", 64'(bus.imem_req_addr), 64'h0);
    tick();
    chk("seq_wait_noreq", 64'(bus.imem_req_valid), 0);
    tick();
    chk("seq_pc0", 64'(bus.inst_pc), 64'h0);
    chk("seq_d0", 64'(bus.inst_data), 64'hC0DE_0000);
    chk("seq_req1_a", 64'(bus.imem_req_addr), 64'h4);
    tick();
    chk("seq_occ_pop", 64'(bus.occupancy), 0);
    tick();
    chk("seq_pc1", 64'(bus.inst_pc), 64'h4);
    chk("seq_d1", 64'(bus.inst_data), 64'hC0DE_0004);
    chk("seq_req2_a", 64'(bus.imem_req_addr), 64'h8);
    tick();
    tick();
    chk("seq_pc2", 64'(bus.inst_pc), 64'h8);
    chk("seq_d2", 64'(bus.inst_data), 64'hC0DE_0008);
    chk("seq_nreq", 64'(nreq), 3);

    // Fill the queue with decode stalled
    bus.inst_ready = 1'b0;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("full_nreq", 64'(nreq), 4);
    chk("full_occ", 64'(bus.occupancy), 4);
    chk("full_noreq", 64'(bus.imem_req_valid), 0);
    chk("full_head", 64'(bus.inst_pc), 64'h0);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    #1;
    chk("pop1_occ", 64'(bus.occupancy), 3);
    chk("pop1_req_v", 64'(bus.imem_req_valid), 1);
    chk("pop1_req_a", 64'(bus.imem_req_addr), 64'h10);
    chk("pop1_head", 64'(bus.inst_pc), 64'h4);
    tick();
    chk("pop1_nreq", 64'(nreq), 5);
    tick();
    chk("refill_occ", 64'(bus.occupancy), 4);

    // Redirect while waiting, response two cycles later is dropped
    bus.inst_ready = 1'b1;
    auto_rsp = 1'b0;
    do_reset();
    rst = 1'b0;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #1;
    chk("drop_noreq_redir", 64'(bus.imem_req_valid), 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("drop_wait_noreq", 64'(bus.imem_req_valid), 0);
    chk("drop_occ0", 64'(bus.occupancy), 0);
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("drop_ival", 64'(bus.inst_valid), 0);
    chk("drop_req_v", 64'(bus.imem_req_valid), 1);
    chk("drop_req_a", 64'(bus.imem_req_addr), 64'h100);

    // Redirect and response in the same cycle
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("same_occ", 64'(bus.occupancy), 0);
    chk("same_req_v", 64'(bus.imem_req_valid), 1);
    chk("same_req_a", 64'(bus.imem_req_addr), 64'h200);

    // Redirect flushes a non-empty queue and gates the request
    auto_rsp = 1'b1;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("flush_pre_occ", 64'(bus.occupancy), 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    #1;
    chk("flush_gate", 64'(bus.imem_req_valid), 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("flush_occ", 64'(bus.occupancy), 0);
    chk("flush_ival", 64'(bus.inst_valid), 0);
    chk("flush_req_a", 64'(bus.imem_req_addr), 64'h300);

    // PC wraps from the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_req_a0", 64'(bus.imem_req_addr), 64'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_head_pc", 64'(bus.inst_pc), 64'hFFFF_FFFC);
    chk("wrap_head_d", 64'(bus.inst_data), 64'hC0DE_FFFC);
    chk("wrap_req_a1", 64'(bus.imem_req_addr), 64'h0);

    // Reset with three entries held and a request outstanding
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_occ3", 64'(bus.occupancy), 3);
    chk("mid_rsp_pend", 64'(bus.imem_rsp_valid), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_occ", 64'(bus.occupancy), 0);
    chk("mid_rst_ival", 64'(bus.inst_valid), 0);
    auto_rsp = 1'b0;
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    #1;
    chk("mid_req_v", 64'(bus.imem_req_valid), 1);
    chk("mid_req_a", 64'(bus.imem_req_addr), 64'h0);
    tick();
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("mid_late_ign", 64'(bus.occupancy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning fetch address width (>=8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address (word aligned).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request present.
REQ-007 SHALL have port imem_req_addr  output  ADDR_W  fetch word address.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_rsp_valid  input  1  instruction word returned (earliest: cycle after acceptance).
REQ-010 SHALL have port imem_rsp_data  input  32  returned instruction.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump redirect from the branch unit.
REQ-012 SHALL have port redirect_pc  input  ADDR_W  redirect target.
REQ-013 SHALL have port inst_valid  output  1  queue head valid.
REQ-014 SHALL have port inst_data  output  32  head instruction.
REQ-015 SHALL have port inst_pc  output  ADDR_W  PC of head instruction.
REQ-016 SHALL have port inst_ready  input  1  decode consumes head.
REQ-017 SHALL have port occupancy  output  $clog2(DEPTH)+1  entries held.

Function
REQ-018 SHALL keep a fetch PC register; bits [1:0] always 0 (redirect_pc[1:0] ignored).
REQ-019 SHALL implement FSM states IDLE, WAIT_RSP, WAIT_DROP.
REQ-020 SHALL assert imem_req_valid in IDLE only when occupancy < DEPTH and redirect_valid is 0; imem_req_addr = fetch PC.
REQ-021 SHALL, on imem_req_valid & imem_req_ready, go IDLE->WAIT_RSP, record fetch PC as pending PC, add 4 to fetch PC (wrap modulo 2^ADDR_W).
REQ-022 SHALL allow at most one outstanding request; no request while in WAIT_RSP or WAIT_DROP.
REQ-023 SHALL, on imem_rsp_valid in WAIT_RSP, push {imem_rsp_data, pending PC} into the queue and return to IDLE; a new request may issue in the following cycle (1 request per 2 cycles max).
REQ-024 SHALL reserve queue space at request time so a response is never dropped for lack of space.
REQ-025 SHALL drive inst_valid = (occupancy != 0), inst_data/inst_pc from head entry, from registered state only (no combinational path from inst_ready).
REQ-026 SHALL pop head on inst_valid & inst_ready; simultaneous push and pop leaves occupancy unchanged.
REQ-027 SHALL, on redirect_valid, set fetch PC = redirect_pc & ~3 and clear the queue (occupancy 0 next cycle); a pop in the same cycle counts as consumed.
REQ-028 SHALL, on redirect_valid in WAIT_RSP without imem_rsp_valid, go to WAIT_DROP; the next response is discarded and FSM returns to IDLE.
REQ-029 SHALL discard a response arriving in the same cycle as redirect_valid (WAIT_RSP->IDLE, no push).
REQ-030 SHALL, on redirect_valid in WAIT_DROP, stay in WAIT_DROP and update fetch PC only.
REQ-031 SHALL, when redirect_valid coincides with request acceptance, suppress acceptance (REQ-020 gating), so no stale request is issued.
REQ-032 SHALL ignore imem_rsp_valid in IDLE.
REQ-033 SHALL keep queue read/write pointers of $clog2(DEPTH) bits wrapping at DEPTH.

Reset
REQ-034 SHALL, with rst high at a clock edge, set fetch PC = RESET_PC, FSM = IDLE, pointers and occupancy = 0, imem_req_valid = 0, inst_valid = 0; rst overrides redirect and responses.
REQ-035 SHALL, on rst asserted mid-request (WAIT_RSP), treat any later response as arriving in IDLE (ignored).
REQ-036 SHALL issue first request (addr RESET_PC) in the first cycle after rst deasserts.

Verification
REQ-037 Bench SHALL cover: reset, memory ready always, 1-cycle response, inst_ready=1 -> addresses 0x0,0x4,0x8 issued every 2 cycles; inst_pc sequence 0x0,0x4,0x8 with matching data.
REQ-038 Bench SHALL cover: DEPTH=4, inst_ready=0 -> exactly 4 requests issued, occupancy=4, imem_req_valid stays 0; then inst_ready=1 for 1 cycle -> occupancy 3, one new request.
REQ-039 Bench SHALL cover: redirect to 0x103 while in WAIT_RSP, response 2 cycles later -> response dropped, next request addr 0x100, queue empty after redirect.
REQ-040 Bench SHALL cover: redirect and imem_rsp_valid same cycle -> no push, next request addr = redirect target.
REQ-041 Bench SHALL cover: fetch PC 0xFFFF_FFFC (ADDR_W=32) accepted -> next request addr 0x0000_0000.
REQ-042 Bench SHALL cover: rst asserted with occupancy 3 and request outstanding -> next cycle occupancy 0, inst_valid 0, then request at RESET_PC.
